// File: rtl/fb_pkg.sv
// Shared constants and types for the frame buffer scanout block.
// Optional build macro FB_CLEAR_ON_RESET_EN enables the post-reset clear sweep.
package fb_pkg;
  localparam int FB_W_DEF       = 160;
  localparam int FB_H_DEF       = 120;
  localparam int SCALE_LOG2_DEF = 2;
  localparam int FB_DEPTH       = FB_W_DEF * FB_H_DEF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fb_state_e;
endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM, read-first, registered read: one write port, one read port.
module fb_ram
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Both accesses in one block with NBA give the old word on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/frame_buffer_scanout.sv
// Frame buffer with pixel-replicated VGA scanout (latency 2) and a write port.
// Build macro FB_CLEAR_ON_RESET_EN: reset enters CLEAR and sweeps BG_COLOR into every word.
module frame_buffer_scanout
  import fb_pkg::*;
#(
  parameter int          FB_W       = FB_W_DEF,
  parameter int          FB_H       = FB_H_DEF,
  parameter int          SCALE_LOG2 = SCALE_LOG2_DEF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] wr_addr,
  input  logic [23:0] wr_data,
  input  logic        wr_en,
  output logic        wr_ready,
  output logic        wr_oob,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_pixels,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        pix_valid,
  output fb_state_e   dbg_state
);
  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int X_LIM = FB_W << SCALE_LOG2;
  localparam int Y_LIM = FB_H << SCALE_LOG2;
`ifdef FB_CLEAR_ON_RESET_EN
  localparam fb_state_e RESET_STATE = ST_CLEAR;
`else
  localparam fb_state_e RESET_STATE = ST_RUN;
`endif

  fb_state_e state_q, state_d;
  logic      wr_ready_q, wr_ready_d;
  logic      oob_q, oob_d;
  logic      vis_q, vis_d;
  logic      act_q, act_d;
  rgb24      pix_q, pix_d;
  logic      pix_valid_q, pix_valid_d;

  logic          wr_hit, wr_in_range, in_range;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [23:0]   ram_wdata, ram_rdata;
`ifdef FB_CLEAR_ON_RESET_EN
  logic [AW-1:0] clr_addr_q, clr_addr_d;
`endif

  // Range checks are done on the full-width coordinates, so the read address never wraps.
  assign in_range    = (32'(x) < 32'(X_LIM)) && (32'(y) < 32'(Y_LIM));
  assign ram_raddr   = in_range ? AW'(32'(y >> SCALE_LOG2) * 32'(FB_W) + 32'(x >> SCALE_LOG2)) : '0;
  assign wr_hit      = wr_en && wr_ready_q;
  assign wr_in_range = 32'(wr_addr) < 32'(DEPTH);

  always_comb begin
    state_d     = state_q;
    oob_d       = oob_q | (wr_hit && !wr_in_range);
    ram_we      = wr_hit && wr_in_range;
    ram_waddr   = AW'(wr_addr);
    ram_wdata   = wr_data;
`ifdef FB_CLEAR_ON_RESET_EN
    clr_addr_d  = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = BG_COLOR;
      if (clr_addr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      else clr_addr_d = clr_addr_q + 1'b1;
    end
`endif
    wr_ready_d  = (state_d == ST_RUN);
    vis_d       = active_pixels && in_range && (state_q == ST_RUN);
    act_d       = active_pixels;
    pix_d       = vis_q ? rgb24'(ram_rdata) : rgb24'(BG_COLOR);
    pix_valid_d = act_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      wr_ready_q  <= (RESET_STATE == ST_RUN);
      oob_q       <= 1'b0;
      vis_q       <= 1'b0;
      act_q       <= 1'b0;
      pix_q       <= rgb24'(BG_COLOR);
      pix_valid_q <= 1'b0;
`ifdef FB_CLEAR_ON_RESET_EN
      clr_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ready_q  <= wr_ready_d;
      oob_q       <= oob_d;
      vis_q       <= vis_d;
      act_q       <= act_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
`ifdef FB_CLEAR_ON_RESET_EN
      clr_addr_q  <= clr_addr_d;
`endif
    end
  end

  fb_ram #(.DEPTH(DEPTH), .AW(AW), .W(24)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign wr_ready  = wr_ready_q;
  assign wr_oob    = oob_q;
  assign pix_r     = pix_q.r;
  assign pix_g     = pix_q.g;
  assign pix_b     = pix_q.b;
  assign pix_valid = pix_valid_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Directed bench for frame_buffer_scanout: scans push expected pixels, a monitor pops them two edges later.
module tb_frame_buffer_scanout;
  import fb_pkg::*;

  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en;
  logic        wr_ready, wr_oob;
  logic [9:0]  x, y;
  logic        active_pixels;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_valid;
  fb_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];
  logic        issue = 1'b0, tag1 = 1'b0, tag2 = 1'b0;
  logic [24:0] mon_got, mon_exp;
  int          scan_idx = 0;

  frame_buffer_scanout dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .wr_ready(wr_ready), .wr_oob(wr_oob),
    .x(x), .y(y), .active_pixels(active_pixels),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
    .dbg_state(dbg_state)
  );

  always #10 clk = ~clk;

  // A scan issued before edge N is due on the outputs after edge N+1.
  always @(posedge clk) begin
    tag1 <= issue;
    tag2 <= tag1;
  end

  always @(negedge clk) begin
    if (tag2) begin
      mon_got = {pix_valid, pix_r, pix_g, pix_b};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scan_unexpected got=%h (no expected entry)", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL scan_%0d got {valid,rgb}=%h expected %h", scan_idx, mon_got, mon_exp);
        end
      end
      scan_idx++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic scan(input int xi, input int yi, input logic act, input logic [23:0] col);
    x = 10'(xi);
    y = 10'(yi);
    active_pixels = act;
    issue = 1'b1;
    exp_q.push_back({act, col});
    @(negedge clk);
    issue = 1'b0;
  endtask

  task automatic write(input int addr, input logic [23:0] data);
    wr_addr = 15'(addr);
    wr_data = data;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic write_scan(input int addr, input logic [23:0] data,
                            input int xi, input int yi, input logic [23:0] col);
    wr_addr = 15'(addr);
    wr_data = data;
    wr_en   = 1'b1;
    scan(xi, yi, 1'b1, col);
    wr_en   = 1'b0;
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog time limit reached");
    finish_run();
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    x = '0; y = '0; active_pixels = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix", {8'h0, pix_r, pix_g, pix_b}, {8'h0, BG});
    check("rst_wr_oob", 32'(wr_oob), 32'd0);
`ifdef FB_CLEAR_ON_RESET_EN
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_CLEAR));
    rst = 1'b0;
    active_pixels = 1'b0;
    begin
      int n;
      n = 0;
      wr_addr = 15'd10; wr_data = 24'hAAAAAA; wr_en = 1'b1;
      while (!wr_ready && n < 30000) begin
        @(negedge clk);
        n++;
      end
      wr_en = 1'b0;
      check("sweep_cycles", 32'(n), 32'd19200);
    end
    check("sweep_no_oob", 32'(wr_oob), 32'd0);
    scan(40, 0, 1'b1, BG);
    scan(0, 0, 1'b1, BG);
    scan(639, 479, 1'b1, BG);
`else
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_RUN));
    rst = 1'b0;
    @(negedge clk);
`endif

    write(0, 24'hFF0000);
    write(161, 24'h00FF00);
    write(162, 24'h0000FF);
    write(5, 24'h111111);
    write(19199, 24'hC0FFEE);

    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++)
        scan(xx, yy, 1'b1, 24'hFF0000);

    scan(4, 4, 1'b1, 24'h00FF00);
    scan(7, 7, 1'b1, 24'h00FF00);
    scan(8, 4, 1'b1, 24'h0000FF);
    scan(639, 479, 1'b1, 24'hC0FFEE);
    scan(636, 476, 1'b1, 24'hC0FFEE);

    scan(0, 0, 1'b0, BG);
    scan(640, 0, 1'b0, BG);
    scan(640, 0, 1'b1, BG);
    scan(0, 480, 1'b1, BG);

    write_scan(5, 24'hABCDEF, 20, 0, 24'h111111);
    scan(21, 1, 1'b1, 24'hABCDEF);
    repeat (4) @(negedge clk);

    check("oob_before", 32'(wr_oob), 32'd0);
    write(19200, 24'h777777);
    check("oob_set", 32'(wr_oob), 32'd1);
    write(32767, 24'h123123);
    write(3, 24'h0F0F0F);
    check("oob_sticky", 32'(wr_oob), 32'd1);
    scan(0, 0, 1'b1, 24'hFF0000);
    scan(12, 0, 1'b1, 24'h0F0F0F);
    repeat (4) @(negedge clk);

    active_pixels = 1'b1; x = 10'd4; y = 10'd4;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_pix_valid", 32'(pix_valid), 32'd0);
    check("rst2_pix", {8'h0, pix_r, pix_g, pix_b}, {8'h0, BG});
    check("rst2_wr_oob", 32'(wr_oob), 32'd0);
    rst = 1'b0;
    @(negedge clk);
`ifdef FB_CLEAR_ON_RESET_EN
    check("rst2_state", 32'(dbg_state), 32'(ST_CLEAR));
`else
    check("rst2_state", 32'(dbg_state), 32'(ST_RUN));
`endif

    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end
endmodule
